// File: rtl/apb_rr_pkg.sv
// ----------------------------------------------------------------------------
// apb_rr_pkg
// Shared types and default sizing for the round-robin APB master and its
// arbiter.
//   state_e      : master sequencing states (IDLE waits for a grant,
//                  ACCESS holds PSEL until PREADY or timeout)
//   DEF_*        : default parameter values used by the top level
// ----------------------------------------------------------------------------
package apb_rr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant. The requester with the lowest
// index at or above the pointer wins, wrapping past NREQ-1 back to 0.
// Ports:
//   req_i   [NREQ]   request vector
//   ptr_i   [PTR_W]  highest-priority index this cycle (must be < NREQ)
//   grant_o [NREQ]   one-hot grant, all zero when nothing is requesting
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o
);

    always_comb begin
        logic found;
        int   idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            // Walk the requesters starting at the pointer, wrapping once.
            idx = int'(ptr_i) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// ----------------------------------------------------------------------------
// apb_rr_master
// Shares one APB slave port (no PENABLE) between NREQ requesters using
// round-robin arbitration. A transfer is accepted in IDLE, PSEL is held in
// ACCESS until PREADY, and a slave that never answers is aborted after
// TIMEOUT cycles of PSEL with rsp_err=1.
// Ports:
//   PCLK, PRESET              clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (ready is one-hot)
//   req_write/addr/wdata      per-requester command, flattened by index
//   rsp_valid [NREQ]          single-cycle completion pulse to the owner
//   rsp_rdata, rsp_err        completion payload, held until next completion
//   PSEL/PWRITE/PADDR/PWDATA  APB command outputs (registered)
//   PRDATA/PREADY             APB slave response
// ----------------------------------------------------------------------------
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     PSEL,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [PTR_W-1:0]    owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                psel_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [NREQ-1:0]     rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic [NREQ-1:0]     grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                accept;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Grant is only offered while idle; the bus is busy otherwise.
    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
        // Pointer moves just past the winner so it has lowest priority next.
        ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    // PREADY is deliberately ignored here.
                    if (accept) begin
                        pwrite_q <= req_write[grant_idx];
                        paddr_q  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        pwdata_q <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                        psel_q   <= 1'b1;
                        owner_q  <= grant_idx;
                        ptr_q    <= ptr_d;
                        cnt_q    <= '0;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (PREADY) begin
                        psel_q               <= 1'b0;
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_rdata_q          <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q            <= 1'b0;
                        state_q              <= IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // PSEL has now been high for TIMEOUT cycles: abort.
                        psel_q               <= 1'b0;
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_rdata_q          <= '0;
                        rsp_err_q            <= 1'b1;
                        state_q              <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// ----------------------------------------------------------------------------
// tb_apb_rr_master
// Scoreboard bench: the stimulus pushes the expected transfer (grant, APB
// command, PSEL length, response) into a queue; a monitor on the falling
// edge predicts accepts, tracks PSEL and checks every rsp_valid pulse.
// ----------------------------------------------------------------------------
module tb_apb_rr_master;

    localparam int NREQ    = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic                    PCLK = 1'b0;
    logic                    PRESET;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         req_write;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*DATA_W-1:0]  req_wdata;
    logic [NREQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    PSEL;
    logic                    PWRITE;
    logic [ADDR_W-1:0]       PADDR;
    logic [DATA_W-1:0]       PWDATA;
    logic [DATA_W-1:0]       PRDATA;
    logic                    PREADY;

    apb_rr_master #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          len;
        bit          has_rsp;
        logic [31:0] rdata;
        bit          err;
        int          gap;
        int          due;
    } exp_t;

    exp_t expq[$];
    exp_t rspq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    logic [31:0] mem [256];
    bit hang  = 0;
    bit stray = 0;
    int pcnt  = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        PREADY = 1'b0;
        PRDATA = 32'h0;
    end

    // Slave drives on the falling edge: PREADY rises in the 2nd PSEL cycle.
    always @(negedge PCLK) begin
        if (!PSEL) begin
            pcnt   = 0;
            PREADY = stray;
            PRDATA = 32'h0;
        end else begin
            pcnt   = pcnt + 1;
            PREADY = !hang && (pcnt == 2);
            PRDATA = mem[PADDR];
        end
    end

    always @(posedge PCLK) begin
        if (PSEL && PREADY && PWRITE && !PRESET) mem[PADDR] <= PWDATA;
    end

    // ---------------- monitor ----------------
    int   cyc       = 0;
    int   run       = 0;
    int   last_acc  = 0;
    int   accepts   = 0;
    bit   have_cur  = 0;
    exp_t cur;

    always @(negedge PCLK) begin
        cyc++;
        // PSEL tracking for the transfer in flight
        if (PSEL) begin
            run++;
            if (!have_cur) begin
                chk("psel_without_accept", 64'(PSEL), 64'd0);
            end else begin
                chk("pwrite", 64'(PWRITE), 64'(cur.wr));
                chk("paddr", 64'(PADDR), 64'(cur.addr));
                if (cur.wr) chk("pwdata", 64'(PWDATA), 64'(cur.wdata));
            end
        end else if (run > 0) begin
            chk("psel_len", 64'(run), 64'(cur.len));
            run = 0;
            if (have_cur && cur.has_rsp) begin
                cur.due = cyc;
                rspq.push_back(cur);
            end
            have_cur = 0;
        end
        // Responses
        if (rspq.size() > 0 && cyc > rspq[0].due) begin
            chk("rsp_missing", 64'd0, 64'd1);
            void'(rspq.pop_front());
        end
        if (|rsp_valid) begin
            if (rspq.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = rspq.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1 << e.idx));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_time", 64'(cyc), 64'(e.due));
            end
        end
        // Accept happens at the coming rising edge (inputs are stable now).
        if (!PRESET && |(req_valid & req_ready)) begin
            accepts++;
            if (expq.size() == 0) begin
                chk("accept_unexpected", 64'(req_ready), 64'd0);
            end else begin
                cur = expq.pop_front();
                chk("grant", 64'(req_ready), 64'(1 << cur.idx));
                if (cur.gap > 0) chk("accept_gap", 64'(cyc - last_acc), 64'(cur.gap));
                have_cur = 1;
            end
            last_acc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    function automatic exp_t mk(input int idx, input bit wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input int len, input bit has_rsp,
                                input logic [31:0] rdata, input bit err, input int gap);
        exp_t e;
        e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata; e.len = len;
        e.has_rsp = has_rsp; e.rdata = rdata; e.err = err; e.gap = gap; e.due = 0;
        return e;
    endfunction

    task automatic drive(input int idx, input bit wr, input logic [7:0] addr, input logic [31:0] wdata);
        req_write[idx]                = wr;
        req_addr[idx*ADDR_W +: ADDR_W] = addr;
        req_wdata[idx*DATA_W +: DATA_W] = wdata;
        req_valid[idx]                = 1'b1;
    endtask

    // Hold valid until the expected number of accepts have been seen.
    task automatic wait_accepts(input int target);
        int n;
        n = 0;
        while (accepts < target && n < 100) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (accepts < target) chk("accept_timeout", 64'(accepts), 64'(target));
        req_valid = '0;
    endtask

    task automatic issue(input exp_t e);
        int target;
        target = accepts + 1;
        expq.push_back(e);
        drive(e.idx, e.wr, e.addr, e.wdata);
        wait_accepts(target);
    endtask

    task automatic do_reset(input int n);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        repeat (n) @(posedge PCLK);
        #1 PRESET = 1'b0;
    endtask

    initial begin
        int target;
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        do_reset(3);
        @(negedge PCLK);
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_pwrite", 64'(PWRITE), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge PCLK); #1;

        // Write then read back through the other requester.
        issue(mk(0, 1, 8'h10, 32'hDEADBEEF, 2, 1, 32'h0, 0, 0));
        issue(mk(1, 0, 8'h10, 32'h0, 2, 1, 32'hDEADBEEF, 0, 0));
        repeat (6) @(posedge PCLK); #1;

        // Both requesters continuously valid from reset: 0,1,0,1 at 3-cycle pitch.
        do_reset(2);
        expq.push_back(mk(0, 1, 8'h20, 32'hA5A5A5A5, 2, 1, 32'h0, 0, 0));
        expq.push_back(mk(1, 0, 8'h20, 32'h0, 2, 1, 32'hA5A5A5A5, 0, 3));
        expq.push_back(mk(0, 1, 8'h20, 32'hA5A5A5A5, 2, 1, 32'h0, 0, 3));
        expq.push_back(mk(1, 0, 8'h20, 32'h0, 2, 1, 32'hA5A5A5A5, 0, 3));
        target = accepts + 4;
        drive(0, 1, 8'h20, 32'hA5A5A5A5);
        drive(1, 0, 8'h20, 32'h0);
        wait_accepts(target);
        repeat (6) @(posedge PCLK); #1;

        // Hung slave: timeout abort, then a normal transfer.
        hang = 1;
        issue(mk(0, 0, 8'h30, 32'h0, TIMEOUT, 1, 32'h0, 1, 0));
        repeat (20) @(posedge PCLK); #1;
        hang = 0;
        issue(mk(1, 1, 8'h30, 32'h12345678, 2, 1, 32'h0, 0, 0));
        repeat (6) @(posedge PCLK); #1;

        // Reset during the 2nd ACCESS cycle: PSEL drops, no response.
        issue(mk(0, 1, 8'h40, 32'h00000055, 2, 0, 32'h0, 0, 0));
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("midrst_psel", 64'(PSEL), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        issue(mk(1, 0, 8'h10, 32'h0, 2, 1, 32'hDEADBEEF, 0, 0));
        repeat (6) @(posedge PCLK); #1;

        // Stray PREADY while idle with no requests.
        stray = 1;
        repeat (5) @(posedge PCLK);
        @(negedge PCLK);
        chk("stray_psel", 64'(PSEL), 64'd0);
        chk("stray_req_ready", 64'(req_ready), 64'd0);
        chk("stray_paddr", 64'(PADDR), 64'h10);
        chk("stray_pwrite", 64'(PWRITE), 64'd0);
        chk("stray_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("stray_rsp_err", 64'(rsp_err), 64'd0);
        stray = 0;
        repeat (5) @(posedge PCLK);
        @(negedge PCLK);
        chk("expq_empty", 64'(expq.size()), 64'd0);
        chk("rspq_empty", 64'(rspq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Multi-requester APB master that shares one APB slave port (PSEL/PWRITE/PADDR/PWDATA/PRDATA/PREADY, no PENABLE) between NREQ internal requesters.
- Arbitration is round-robin.
- Each transfer is sequenced with PSEL held until PREADY is seen.
- A hung slave is bounded by a timeout.
- Sits between bus-using agents (DMA, CPU bridge, config engine) and the register/RAM slaves.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 8, APB address width
DATA_W, 32, APB data width
TIMEOUT, 15, max cycles PSEL may stay high without PREADY (>=3)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot grant/accept
req_write  in  NREQ  1=write, 0=read
req_addr  in  NREQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  flattened write data
rsp_valid  out  NREQ  one-cycle completion pulse to owning requester
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  qualified by rsp_valid: 1 = timeout abort
PSEL  out  1  APB select
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB completion

Behaviour:
- Clock and reset: one clock PCLK; PRESET is synchronous, active-high.
- Reset values: PSEL=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, rr pointer=0, timeout count=0.
- Reset mid-transfer: PSEL drops at the reset edge and no rsp_valid is issued.
- States:
  - IDLE: req_ready = combinational one-hot grant. Grant goes to the lowest index >= pointer with req_valid, wrapping. req_ready=0 if no valid request.
  - ACCESS: req_ready=0.
- Handshake:
  - Accept at a rising edge when req_valid[i] && req_ready[i].
  - Requester holds write/addr/wdata stable while valid and not yet ready.
  - At accept: register PWRITE/PADDR/PWDATA from requester i, PSEL<=1, owner<=i, pointer<=(i+1) mod NREQ, count<=0, state<=ACCESS.
- ACCESS, each edge:
  - If PREADY=1: PSEL<=0; rsp_valid[owner]<=1; rsp_rdata<=PWRITE?0:PRDATA; rsp_err<=0; state<=IDLE.
  - Else if count==TIMEOUT-1: PSEL<=0; rsp_valid[owner]<=1; rsp_err<=1; rsp_rdata<=0; state<=IDLE.
  - Else: count++.
- PADDR/PWRITE/PWDATA are held from accept until the next accept.
- Slave timing (slave acts on the falling edge, PREADY visible in 2nd PSEL cycle):
  - Accept edge E0; PSEL high for cycles after E0 and E1; PREADY sampled at E2.
  - rsp_valid visible for the cycle after E2.
  - Earliest next accept at E3, so PSEL is low for at least one full cycle between transfers.
  - Best-case throughput: one transfer per 3 cycles.
- rsp_valid is a single-cycle pulse. rsp_rdata/rsp_err hold until the next completion.
- A new request arriving while in ACCESS waits. Simultaneous requests are resolved by the pointer, so no requester starves (worst wait NREQ-1 transfers).
- PREADY=1 while in IDLE is ignored.

Decomposition:
- Package apb_rr_pkg holds:
  - state enum {IDLE, ACCESS}
  - default ADDR_W/DATA_W constants
  - TIMEOUT default
- Sub-module rr_arbiter:
  - inputs: NREQ request vector, pointer
  - output: one-hot grant
  - combinational, reusable by other shared-bus blocks.

Test Plan:
- Reset then req0 write addr=0x10 data=0xDEADBEEF; slave model asserts PREADY in 2nd PSEL cycle -> PSEL high exactly 2 cycles, PWRITE=1, PADDR=0x10; rsp_valid[0] pulse 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- req1 read addr=0x10 after the above write, slave memory returns 0xDEADBEEF -> rsp_valid[1] pulse, rsp_rdata=0xDEADBEEF, PWRITE=0.
- req0 and req1 both valid continuously for 4 transfers from reset -> grants 0,1,0,1; PSEL low >=1 cycle between transfers; 3-cycle spacing between accepts.
- Slave never asserts PREADY -> PSEL high exactly TIMEOUT (15) cycles then low; rsp_valid[owner] pulse with rsp_err=1, rsp_rdata=0; a following normal transfer completes with rsp_err=0.
- PRESET asserted in 2nd ACCESS cycle -> PSEL=0 next cycle, no rsp_valid; after release, req1 valid is granted (pointer reset to 0, req0 idle).
- Stray PREADY=1 while IDLE with no requests -> no rsp_valid, state stays IDLE, outputs unchanged.
